// File: rtl/addsub_nibble_seq.sv
// Nibble-serial two's-complement adder/subtractor: one 4-bit slice reused LSB nibble first.
// Optional macro ADDSUB_SAT_EN saturates the result on signed overflow.
module addsub_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 carry,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

`ifdef ADDSUB_SAT_EN
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic          armed;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic [IW-1:0] idx;
    logic          c_reg;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    low3;
    logic [1:0]    top;
    logic [3:0]    slice_sum;
    logic          c3;
    logic          c4;

    // armed holds in_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid && in_ready) state_next = RUN;
            RUN:  if (idx == LAST_IDX)      state_next = DONE;
            DONE: if (out_ready)            state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && armed;
        out_valid = (state == DONE);
    end

    // The slice is split at bit 2 so the carry into the top bit is visible for overflow
    always_comb begin
        a_nib     = 4'(a_reg >> {idx, 2'b00});
        b_nib     = 4'(b_reg >> {idx, 2'b00}) ^ {4{sub_reg}};
        low3      = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, c_reg};
        top       = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, low3[3]};
        slice_sum = {top[0], low3[2:0]};
        c3        = low3[3];
        c4        = top[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            idx     <= '0;
            c_reg   <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sub_reg <= sub;
                        idx     <= '0;
                        c_reg   <= sub;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= slice_sum;
                    c_reg <= c4;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        carry <= c4;
                        ovf   <= c3 ^ c4;
`ifdef ADDSUB_SAT_EN
                        if (c3 ^ c4)
                            result <= a_reg[W-1] ? SAT_NEG : SAT_POS;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/addsub_nibble_seq.md
ADDSUB_NIBBLE_SEQ -- requirements
Module: addsub_nibble_seq

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports: a, b  input  W  operands, two's complement.
REQ-007 SHALL have port: sub  input  1  0 = a+b, 1 = a-b.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: result  output  W  sum or difference.
REQ-011 SHALL have ports: carry, ovf  output  1 each  top-slice carry-out; signed overflow.

Function
REQ-012 SHALL use exactly one 4-bit add/sub slice computing a_n + (b_n XOR {4{sub}}) + c, reused once per nibble, LSB nibble first.
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; no other states.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready SHALL latch a, b, sub, set nibble index 0, carry register = sub, go RUN, clear in_ready.
REQ-015 RUN: each cycle SHALL process nibble[index], write result nibble, carry register <= slice carry-out, index+1; after nibble NIBBLES-1, go DONE.
REQ-016 SHALL compute ovf = carry-out(bit W-1) XOR carry-out(bit W-2) of the top slice, carry = carry-out(bit W-1).
REQ-017 Latency: acceptance on edge E0 SHALL give out_valid=1 after edge E0+NIBBLES.
REQ-018 DONE: out_valid=1; result, carry, ovf SHALL stay stable until out_ready=1; on that edge clear out_valid, set in_ready, go IDLE.
REQ-019 in_valid SHALL be ignored in RUN and DONE; out_ready SHALL be ignored when out_valid=0.
REQ-020 No overlap: next acceptance earliest one edge after the DONE handshake; max throughput one op per NIBBLES+2 cycles.
REQ-021 Operand inputs SHALL not need to be held after acceptance.
REQ-022 Arithmetic SHALL wrap modulo 2^W; for sub=1, carry=1 means no borrow.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, in_ready=0, out_valid=0, result=0, carry=0, ovf=0, index=0.
REQ-024 in_ready SHALL become 1 on the first clk edge after rst_n release.
REQ-025 Reset during RUN or DONE SHALL discard the operation; no out_valid for it.

Configuration
REQ-026 Macro ADDSUB_SAT_EN defined: when ovf=1 on entry to DONE, result SHALL be replaced by 0x7F..F if a[W-1]=0, else 0x80..0; ovf still reported as 1.
REQ-027 Macro ADDSUB_SAT_EN undefined: result SHALL be the wrapped value; no saturation logic present.

Verification
REQ-028 a=0x1234, b=0x0FCD, sub=0 -> result=0x2201, carry=0, ovf=0, out_valid exactly 4 edges after accept.
REQ-029 a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, carry=0, ovf=0.
REQ-030 a=0x7FFF, b=0x0001, sub=0 -> ovf=1; result=0x8000 without ADDSUB_SAT_EN, 0x7FFF with it.
REQ-031 a=0x8000, b=0x0001, sub=1 -> ovf=1, carry=1; result=0x7FFF without ADDSUB_SAT_EN, 0x8000 with it.
REQ-032 out_ready low 10 cycles in DONE with in_valid=1 and changing a/b -> result stable, in_ready=0, no acceptance; out_ready pulse -> IDLE, in_ready=1 next cycle.
REQ-033 rst_n low during RUN nibble 2 -> out_valid=0, result=0 immediately; after release next request 0x0001+0x0001 -> 0x0002.
